instruction_fetch: RTL

//   Fetch-stage initiator for instruction_memory. Owns the PC, drives the word

---
 rtl/instruction_fetch.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch-stage initiator for instruction_memory. Owns the program counter and
//   drives it as the word address of the memory's combinational read port.
//   The returned word is captured into the IF/ID register one clock later.
//   Also handles:
//     - pipeline stall (PC and IF/ID hold),
//     - branch/jump redirect, with an optional MIPS delay slot,
//     - a redirect pending register for redirects that arrive during a stall,
//     - a sticky fault when the PC leaves the instruction window.
//
// Ports
//   clock             in   1   rising-edge clock
//   reset             in   1   asynchronous, active-high reset
//   imem_address      out  30  word address to instruction_memory (= pc)
//   imem_instruction  in   32  word returned combinationally for imem_address
//   stall             in   1   hold PC and IF/ID register this cycle
//   redirect_valid    in   1   branch/jump taken this cycle
//   redirect_target   in   30  word address of the redirect target
//   fetch_valid       out  1   IF/ID register holds a real instruction
//   fetch_instruction out  32  IF/ID instruction word
//   fetch_pc          out  30  word address of fetch_instruction
//   fetch_fault       out  1   sticky: PC left the instruction window
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] START_BYTE_ADDR = 32'h0000_3000,
  parameter int unsigned MEM_WORDS       = 1024,
  parameter bit          DELAY_SLOT      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [29:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_target,
  output logic        fetch_valid,
  output logic [31:0] fetch_instruction,
  output logic [29:0] fetch_pc,
  output logic        fetch_fault
);

  localparam logic [29:0] START_WORD   = START_BYTE_ADDR[31:2];
  localparam logic [29:0] WINDOW_WORDS = 30'(MEM_WORDS);

  // Fetch runs until the PC leaves the window; the fault state is sticky.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_instruction_q, fetch_instruction_d;
  logic [29:0] fetch_pc_q, fetch_pc_d;
  logic        pending_valid_q, pending_valid_d;
  logic [29:0] pending_target_q, pending_target_d;

  logic [29:0] pc_offset_s;
  logic        in_range_s;
  logic        redirect_taken_s;
  logic [29:0] redirect_eff_s;
  logic [29:0] pc_inc_s;

  // Window test and redirect selection derived from current state and inputs.
  always_comb begin
    // Unsigned subtract: a PC below the window wraps to a huge offset.
    pc_offset_s      = pc_q - START_WORD;
    in_range_s       = (pc_offset_s < WINDOW_WORDS);
    // A fresh redirect overrides one parked during an earlier stall.
    redirect_taken_s = redirect_valid | pending_valid_q;
    if (redirect_valid) begin
      redirect_eff_s = redirect_target;
    end else begin
      redirect_eff_s = pending_target_q;
    end
    pc_inc_s = pc_q + 30'd1;
  end

  // Next-state logic: fault freeze, stall hold, or advance.
  always_comb begin
    state_d             = state_q;
    pc_d                = pc_q;
    fetch_valid_d       = fetch_valid_q;
    fetch_instruction_d = fetch_instruction_q;
    fetch_pc_d          = fetch_pc_q;
    pending_valid_d     = pending_valid_q;
    pending_target_d    = pending_target_q;

    case (state_q)
      ST_FAULT: begin
        // Frozen until reset; redirects are ignored.
        fetch_valid_d = 1'b0;
      end

      ST_RUN: begin
        if (stall) begin
          // PC and IF/ID hold; a redirect is parked for the next advance.
          if (redirect_valid) begin
            pending_valid_d  = 1'b1;
            pending_target_d = redirect_target;
          end else begin
            pending_valid_d  = pending_valid_q;
          end
        end else if (!in_range_s) begin
          state_d         = ST_FAULT;
          fetch_valid_d   = 1'b0;
          pending_valid_d = 1'b0;
        end else if (redirect_taken_s) begin
          pc_d            = redirect_eff_s;
          pending_valid_d = 1'b0;
          if (DELAY_SLOT) begin
            // The word fetched in the redirect cycle is the delay slot.
            fetch_valid_d       = 1'b1;
            fetch_instruction_d = imem_instruction;
            fetch_pc_d          = pc_q;
          end else begin
            // Squash it: bubble, IF/ID contents left as they were.
            fetch_valid_d = 1'b0;
          end
        end else begin
          fetch_valid_d       = 1'b1;
          fetch_instruction_d = imem_instruction;
          fetch_pc_d          = pc_q;
          pc_d                = pc_inc_s;
        end
      end

      default: begin
        // Unreachable encoding: fail safe into the frozen state.
        state_d         = ST_FAULT;
        fetch_valid_d   = 1'b0;
        pending_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset to the start of the window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q             <= ST_RUN;
      pc_q                <= START_WORD;
      fetch_valid_q       <= 1'b0;
      fetch_instruction_q <= 32'h0000_0000;
      fetch_pc_q          <= START_WORD;
      pending_valid_q     <= 1'b0;
      pending_target_q    <= 30'd0;
    end else begin
      state_q             <= state_d;
      pc_q                <= pc_d;
      fetch_valid_q       <= fetch_valid_d;
      fetch_instruction_q <= fetch_instruction_d;
      fetch_pc_q          <= fetch_pc_d;
      pending_valid_q     <= pending_valid_d;
      pending_target_q    <= pending_target_d;
    end
  end

  assign imem_address      = pc_q;
  assign fetch_valid       = fetch_valid_q;
  assign fetch_instruction = fetch_instruction_q;
  assign fetch_pc          = fetch_pc_q;
  assign fetch_fault       = (state_q == ST_FAULT);

endmodule
